stream_noise_filter: RTL and testbench
======================================

# stream_noise_filter

Streaming 3x3 impulse-noise filter that sits between the pixel source (camera/gray converter) and the style pipeline. It accepts a raster stream of RGB plus gray pixels and keeps two gray line buffers and a centre-RGB delay line internally. For each centre pixel it replaces any colour channel that deviates from its 3x3 mean by more than a threshold. It adds a mode select, parametrised width and line length, border pass-through, and an end-of-frame flush, so the output pixel count equals the input pixel count.

## Interface
- DW, 8: bits per channel (gray, R, G, B).
- LINE_W, 640: pixels per line; line buffers hold LINE_W entries.
- THR, 200: deviation threshold, DW bits, unsigned.
- iCLK  in  1  pixel clock; all state on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iFVAL  in  1  frame valid; a rising edge starts a frame, a falling edge ends it.
- iDVAL  in  1  pixel valid; sampled only while iFVAL=1.
- iRed, iGreen, iBlue  in  DW each  centre-colour source.
- iGray  in  DW  gray value of the same pixel, used for the window.
- iMODE  in  2  00 bypass, 01 thresholded mean, 10 unconditional mean, 11 treated as 00; sampled at frame start only.
- oDVAL  out  1  output pixel valid.
- oRed, oGreen, oBlue  out  DW each  filtered pixel.
- oBUSY  out  1  high in FILL, RUN and FLUSH.
- oERR  out  1  sticky; set when a pixel is dropped; cleared only by iRST.

## Operation
- FSM states and transitions:
  - IDLE -> FILL on an iFVAL rising edge. This clears the column/row counters and the pending counter, and latches iMODE.
  - FILL -> RUN once LINE_W+1 pixels have been accepted.
  - FILL or RUN -> FLUSH on an iFVAL falling edge.
  - FLUSH -> IDLE when pending reaches 0.
- Accepted pixel (iFVAL & iDVAL, state FILL or RUN):
  - Shifts iGray into the line buffers and window.
  - Pushes {R,G,B} into the (LINE_W+1)-deep delay line.
  - Column counter wraps at LINE_W-1, then the row counter increments.
  - Pending counter = min(accepted, LINE_W+1).
- Centre pixel = the pixel accepted LINE_W+1 pixels earlier. In RUN, every accepted pixel produces exactly one output for the centre.
- FLUSH: one output per cycle, pending decrements, iDVAL is ignored. Any iDVAL=1 while iFVAL=1 in FLUSH or IDLE is dropped and sets oERR.
- Border pixels are output as the raw centre RGB. A pixel is a border pixel if:
  - its centre column is 0 or LINE_W-1, or
  - its centre row is 0, or
  - it is emitted during FLUSH.
- Arithmetic per channel ch, interior pixels only:
  - sum = centre_ch + the 8 gray neighbours, width DW+4.
  - mean = floor(sum/9), which always fits in DW bits.
  - dev = |centre_ch - mean|, unsigned, no wrap.
- Selection by latched mode:
  - mode 01: out = (dev > THR) ? mean : centre_ch. Strict compare; dev = THR keeps the centre.
  - mode 10: out = mean.
  - mode 00/11: out = centre_ch.
- Reset mid-frame: state returns to IDLE, counters clear, and the in-flight pipeline is discarded. Line-buffer contents are don't-care. Filtering resumes only at the next iFVAL rising edge.

## Timing
- Reset values: oDVAL=0, oRed=oGreen=oBlue=0, oBUSY=0, oERR=0, state=IDLE.
- Pipeline: window/delay update (cycle 0) -> sum/mean register (cycle 1) -> select/output register (cycle 2).
- oDVAL rises 2 cycles after the accepting edge of the pixel that completes a window, and 2 cycles after each FLUSH issue cycle.
- No back-pressure. One output per issue; outputs preserve raster order.
- Simultaneous iFVAL fall and iDVAL=1: the pixel is ignored. iFVAL=0 gates acceptance.
- iFVAL rising while in FLUSH: the flush completes, the new frame is not started, pixels are dropped and oERR is set. Upstream blanking must be at least LINE_W+3 cycles.
- Frame shorter than LINE_W+1 pixels: FILL -> FLUSH emits exactly the accepted count, all pass-through.
- Total outputs per frame = accepted pixels.

## Test plan
- Flat frame: LINE_W=8, 4 rows, all channels and gray = 100, mode 01 -> 32 outputs, all 100; first oDVAL LINE_W+3 cycles after the first pixel at 1 pixel/cycle.
- Impulse: gray = 10 everywhere, interior centre R=255, G=B=10, mode 01, THR=200 -> that pixel outputs R=floor((255+80)/9)=37 and G=B=10 (dev 0).
- Threshold edge: centre R chosen so dev = 200 exactly -> R unchanged; dev = 201 -> replaced by the mean.
- Mode 10 on the same impulse frame -> every interior channel equals its mean; border pixels are raw. Mode 11 -> output identical to input.
- Frame end: iFVAL falls after 32 pixels -> the last 9 outputs come in 9 consecutive FLUSH cycles as pass-through. oBUSY falls after them. iDVAL=1 during FLUSH with iFVAL=1 sets oERR.
- Reset asserted mid-RUN -> all outputs 0 immediately. The next frame behaves as in scenario 1 with no stale pixels emitted.

Source files
------------

// File: rtl/stream_noise_filter.sv
// Streaming 3x3 impulse-noise filter: colour channels far from their local mean are replaced by it.
// Output comes 2 cycles after the issuing edge; no back-pressure, end-of-frame flush drains the delay line.
module stream_noise_filter #(
  parameter int             DW     = 8,
  parameter int             LINE_W = 640,
  parameter logic [DW-1:0]  THR    = DW'(200)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [DW-1:0] iGray,
  input  logic [1:0]    iMODE,
  output logic          oDVAL,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oBUSY,
  output logic          oERR
);

  localparam int CW = $clog2(LINE_W);
  localparam int PW = $clog2(LINE_W + 1);
  localparam int NW = $clog2(LINE_W + 2);
  localparam int SW = DW + 4;
  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_W - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(LINE_W);
  localparam logic [NW-1:0] PEND_FILL = NW'(LINE_W);
  localparam logic [NW-1:0] PEND_ONE  = NW'(1);
  localparam logic [SW-1:0] NINE      = SW'(9);

  typedef logic [2:0][DW-1:0] rgb_t;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic          fval_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] col_q, cc_q;
  logic          row_nz_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] pend_q;
  logic          err_q;

  logic fval_rise, fval_fall, accept, drop;
  logic start, issue, flushing;

  logic [DW-1:0] lb1_q [LINE_W];
  logic [DW-1:0] lb2_q [LINE_W];
  rgb_t          dl_q  [LINE_W+1];
  logic [DW-1:0] win_q [3][3];

  logic          s0_vld_q, s0_border_q;
  logic [1:0]    s0_mode_q;
  rgb_t          s0_rgb_q;
  logic          s1_vld_q, s1_border_q;
  logic [1:0]    s1_mode_q;
  rgb_t          s1_rgb_q, s1_mean_q;
  logic          out_vld_q;
  rgb_t          out_rgb_q;

  logic [SW-1:0] nbr_sum;
  rgb_t          mean_d, sel_d;
  logic [DW-1:0] dev;

  assign fval_rise = iFVAL & ~fval_q;
  assign fval_fall = ~iFVAL & fval_q;
  assign accept    = iFVAL & iDVAL & ((state_q == FILL) || (state_q == RUN));
  assign drop      = iFVAL & iDVAL & ((state_q == IDLE) || (state_q == FLUSH));

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    issue    = 1'b0;
    flushing = 1'b0;
    case (state_q)
      IDLE: begin
        if (fval_rise) begin
          state_d = FILL;
          start   = 1'b1;
        end
      end
      FILL: begin
        if (fval_fall) state_d = FLUSH;
        else if (accept && (pend_q == PEND_FILL)) state_d = RUN;
      end
      RUN: begin
        issue = accept;
        if (fval_fall) state_d = FLUSH;
      end
      FLUSH: begin
        issue    = (pend_q != '0);
        flushing = issue;
        if (pend_q <= PEND_ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // fval_q resets high so a frame already in progress at reset release is not taken as a new start
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      fval_q   <= 1'b1;
      mode_q   <= '0;
      col_q    <= '0;
      cc_q     <= '0;
      row_nz_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      if (drop) err_q <= 1'b1;
      if (start) begin
        mode_q   <= iMODE;
        col_q    <= '0;
        cc_q     <= '0;
        row_nz_q <= 1'b0;
        wr_q     <= '0;
        rd_q     <= '0;
        pend_q   <= '0;
      end else begin
        if (accept) begin
          col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          wr_q  <= (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
          if (state_q == FILL) pend_q <= pend_q + 1'b1;
        end
        if (issue) begin
          rd_q <= (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
          if (cc_q == COL_LAST) begin
            cc_q     <= '0;
            row_nz_q <= 1'b1;
          end else begin
            cc_q <= cc_q + 1'b1;
          end
        end
        if (flushing) pend_q <= pend_q - 1'b1;
      end
    end
  end

  // Column 0 of the window holds the newest pixel, so win_q[1][1] is the centre
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1_q[col_q] <= iGray;
      lb2_q[col_q] <= lb1_q[col_q];
      dl_q[wr_q]   <= {iRed, iGreen, iBlue};
      for (int r = 0; r < 3; r++) begin
        for (int c = 1; c < 3; c++) begin
          win_q[r][c] <= win_q[r][c-1];
        end
      end
      win_q[2][0] <= iGray;
      win_q[1][0] <= lb1_q[col_q];
      win_q[0][0] <= lb2_q[col_q];
    end
  end

  always_comb begin
    nbr_sum = '0;
    mean_d  = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((r == 1) && (c == 1))) nbr_sum = nbr_sum + SW'(win_q[r][c]);
      end
    end
    for (int ch = 0; ch < 3; ch++) begin
      mean_d[ch] = DW'((nbr_sum + SW'(s0_rgb_q[ch])) / NINE);
    end
  end

  always_comb begin
    sel_d = s1_rgb_q;
    dev   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      dev = (s1_rgb_q[ch] >= s1_mean_q[ch]) ? (s1_rgb_q[ch] - s1_mean_q[ch])
                                            : (s1_mean_q[ch] - s1_rgb_q[ch]);
      if (!s1_border_q) begin
        if (s1_mode_q == 2'b10) sel_d[ch] = s1_mean_q[ch];
        else if ((s1_mode_q == 2'b01) && (dev > THR)) sel_d[ch] = s1_mean_q[ch];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s0_vld_q    <= 1'b0;
      s0_border_q <= 1'b0;
      s0_mode_q   <= '0;
      s0_rgb_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_mode_q   <= '0;
      s1_rgb_q    <= '0;
      s1_mean_q   <= '0;
      out_vld_q   <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      s0_vld_q    <= issue;
      s0_border_q <= flushing | (cc_q == '0) | (cc_q == COL_LAST) | ~row_nz_q;
      s0_mode_q   <= mode_q;
      s0_rgb_q    <= dl_q[rd_q];
      s1_vld_q    <= s0_vld_q;
      s1_border_q <= s0_border_q;
      s1_mode_q   <= s0_mode_q;
      s1_rgb_q    <= s0_rgb_q;
      s1_mean_q   <= mean_d;
      out_vld_q   <= s1_vld_q;
      if (s1_vld_q) out_rgb_q <= sel_d;
    end
  end

  assign oDVAL  = out_vld_q;
  assign oRed   = out_rgb_q[2];
  assign oGreen = out_rgb_q[1];
  assign oBlue  = out_rgb_q[0];
  assign oBUSY  = (state_q != IDLE);
  assign oERR   = err_q;

endmodule

// File: tb/tb_stream_noise_filter.sv
// Randomised and directed frames for stream_noise_filter, checked against an index-based window model.
module tb_stream_noise_filter;
  localparam int DW  = 8;
  localparam int LW  = 8;
  localparam int THR = 200;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iFVAL, iDVAL;
  logic [DW-1:0] iRed, iGreen, iBlue, iGray;
  logic [1:0]    iMODE;
  logic          oDVAL, oBUSY, oERR;
  logic [DW-1:0] oRed, oGreen, oBlue;

  stream_noise_filter #(.DW(DW), .LINE_W(LW), .THR(8'(THR))) dut (
    .iCLK(clk), .iRST(rst), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iGray(iGray), .iMODE(iMODE),
    .oDVAL(oDVAL), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 clk = ~clk;

  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   t_first = 0;
  pix_t exp_q[$];
  pix_t got_q[$];
  int   ocyc_q[$];
  pix_t src[64];
  logic [7:0] gy[64];
  pix_t cmp_act, cmp_exp;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && oDVAL) begin
      cmp_act = {oRed, oGreen, oBlue};
      ncmp++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_output: got %h, required no output", cmp_act);
      end else begin
        cmp_exp = exp_q.pop_front();
        if (cmp_act !== cmp_exp) begin
          nfail++;
          $display("FAIL pixel_%0d: got %h required %h", got_q.size(), cmp_act, cmp_exp);
        end
      end
      got_q.push_back(cmp_act);
      ocyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic pix_t gq(input int i);
    if (i < got_q.size()) return got_q[i];
    return '0;
  endfunction

  function automatic int oc(input int i);
    if (i < ocyc_q.size()) return ocyc_q[i];
    return -1000;
  endfunction

  // Expected output for pixel i of an n-pixel frame, straight from the window definition
  function automatic pix_t model_pix(input int i, input int n, input logic [1:0] mode);
    int   row, col, s, m, d;
    int   cv[3];
    pix_t o;
    row = i / LW;
    col = i % LW;
    o   = src[i];
    if (row == 0 || col == 0 || col == LW-1 || i + LW + 1 >= n || mode == 2'b00 || mode == 2'b11)
      return o;
    cv[0] = int'(src[i].r);
    cv[1] = int'(src[i].g);
    cv[2] = int'(src[i].b);
    for (int k = 0; k < 3; k++) begin
      s = cv[k];
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (dr != 0 || dc != 0) s += int'(gy[i + dr*LW + dc]);
      m = s / 9;
      d = (cv[k] > m) ? cv[k] - m : m - cv[k];
      if (mode == 2'b10 || d > THR) cv[k] = m;
    end
    o.r = 8'(cv[0]);
    o.g = 8'(cv[1]);
    o.b = 8'(cv[2]);
    return o;
  endfunction

  task automatic fill_flat(input int g, input int c);
    for (int i = 0; i < 64; i++) begin
      gy[i]  = 8'(g);
      src[i] = '{8'(c), 8'(c), 8'(c)};
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      gy[i]    = 8'($urandom);
      src[i].r = 8'($urandom);
      src[i].g = 8'($urandom);
      src[i].b = 8'($urandom);
    end
  endtask

  task automatic drive_pix(input int idx);
    iDVAL  = 1'b1;
    iRed   = src[idx].r;
    iGreen = src[idx].g;
    iBlue  = src[idx].b;
    iGray  = gy[idx];
  endtask

  task automatic run_frame(input logic [1:0] mode, input int n, input int gap_pct, input bit inject);
    int idx;
    exp_q.delete();
    got_q.delete();
    ocyc_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model_pix(i, n, mode));
    @(negedge clk);
    iFVAL = 1'b1;
    iDVAL = 1'b0;
    iMODE = mode;
    idx = 0;
    while (idx < n) begin
      @(negedge clk);
      if (idx == 1) chk("busy_in_frame", int'(oBUSY), 1);
      iMODE = 2'($urandom);
      if (int'($urandom_range(99)) < gap_pct) iDVAL = 1'b0;
      else begin
        drive_pix(idx);
        if (idx == 0) t_first = cyc + 1;
        idx++;
      end
    end
    @(negedge clk);
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    if (inject) begin
      @(negedge clk);
      iFVAL = 1'b1;
      iDVAL = 1'b1;
      repeat (4) @(negedge clk);
      iFVAL = 1'b0;
      iDVAL = 1'b0;
    end
    repeat (LW + 8) @(negedge clk);
    chk("out_count", got_q.size(), n);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_after", int'(oBUSY), 0);
  endtask

  task automatic check_flat_frame(input string tag);
    run_frame(2'b01, 32, 0, 1'b0);
    chk({tag, "_first_latency"}, oc(0) - t_first, LW + 3);
    chk({tag, "_flush_span"}, oc(31) - oc(23), 8);
    chk({tag, "_gap_before_flush"}, oc(23) - oc(22), 2);
    chk({tag, "_px13_r"}, int'(gq(13).r), 100);
    chk({tag, "_px31_b"}, int'(gq(31).b), 100);
    chk({tag, "_err"}, int'(oERR), 0);
  endtask

  initial begin
    iFVAL = 1'b0; iDVAL = 1'b0; iMODE = 2'b00;
    iRed = '0; iGreen = '0; iBlue = '0; iGray = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dval", int'(oDVAL), 0);
    chk("rst_red", int'(oRed), 0);
    chk("rst_green", int'(oGreen), 0);
    chk("rst_blue", int'(oBlue), 0);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_err", int'(oERR), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    fill_flat(100, 100);
    check_flat_frame("flat");

    fill_flat(10, 10);
    src[8].r  = 8'd255;
    src[11].r = 8'd255;
    src[12].g = 8'd50;
    src[13].r = 8'd235;
    src[20].r = 8'd236;
    src[27].r = 8'd200;
    run_frame(2'b01, 32, 0, 1'b0);
    chk("m01_impulse_r", int'(gq(11).r), 37);
    chk("m01_impulse_g", int'(gq(11).g), 10);
    chk("m01_impulse_b", int'(gq(11).b), 10);
    chk("m01_dev_eq_thr", int'(gq(13).r), 235);
    chk("m01_dev_over_thr", int'(gq(20).r), 35);
    chk("m01_small_dev_kept", int'(gq(12).g), 50);
    chk("m01_border_raw", int'(gq(8).r), 255);
    run_frame(2'b10, 32, 0, 1'b0);
    chk("m10_impulse_r", int'(gq(11).r), 37);
    chk("m10_dev_eq_thr", int'(gq(13).r), 35);
    chk("m10_mean_g", int'(gq(12).g), 14);
    chk("m10_border_raw", int'(gq(8).r), 255);
    chk("m10_flush_raw", int'(gq(27).r), 200);
    run_frame(2'b11, 32, 0, 1'b0);
    chk("m11_impulse_r", int'(gq(11).r), 255);
    chk("m11_over_r", int'(gq(20).r), 236);

    fill_rand();
    run_frame(2'b10, 5, 0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      fill_rand();
      run_frame(2'($urandom), int'($urandom_range(40, 3)), 30, 1'b0);
    end

    fill_rand();
    chk("err_before", int'(oERR), 0);
    run_frame(2'b01, 20, 20, 1'b1);
    chk("err_after_flush_drop", int'(oERR), 1);
    fill_rand();
    run_frame(2'b10, 24, 10, 1'b0);
    chk("err_sticky", int'(oERR), 1);

    fill_rand();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(model_pix(i, 32, 2'b01));
    @(negedge clk);
    iFVAL = 1'b1;
    iMODE = 2'b01;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_pix(i);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dval", int'(oDVAL), 0);
    chk("midrst_red", int'(oRed), 0);
    chk("midrst_green", int'(oGreen), 0);
    chk("midrst_blue", int'(oBlue), 0);
    chk("midrst_busy", int'(oBUSY), 0);
    chk("midrst_err", int'(oERR), 0);
    exp_q.delete();
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fill_flat(100, 100);
    check_flat_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
